// File: rtl/ddr_arbiter_pkg.sv
// Shared types and constants for the DDRAM burst arbiter.
// The arbiter and its bench import this package so that the port roles and default widths are defined in one place.
package ddr_arbiter_pkg;

  localparam int NUM_PORTS = 3;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 64;
  localparam int BURST_W   = 8;
  localparam int MASK_W    = 8;

  // Requester roles; a lower index means a higher priority.
  localparam int PORT_DOWNLOAD = 0;
  localparam int PORT_FB       = 1;
  localparam int PORT_CACHE    = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_CMD  = 2'd1,
    READ_DATA = 2'd2,
    WRITE     = 2'd3
  } state_t;

endpackage

// File: rtl/ddr_arbiter_prio_encoder.sv
// Fixed-priority encoder: the lowest-index active request wins.
// It returns the winner as a one-hot vector and as a binary index, together with a flag that is set when any request is active.
module prio_encoder #(
  parameter  int N     = 3,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // NOTE: every output gets a default before the loop, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = |req;
    // The loop walks downward, so the lowest active index is the last write and wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot = N'(1) << i;
        idx    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ddr_arbiter.sv
// Fixed-priority burst arbiter that shares the single DDRAM port between requesters.
// It grants one whole read or write burst at a time and returns the handshake and the read data to the winning port.
module ddr_arbiter #(
  parameter int NUM_PORTS = ddr_arbiter_pkg::NUM_PORTS,
  parameter int ADDR_W    = ddr_arbiter_pkg::ADDR_W,
  parameter int DATA_W    = ddr_arbiter_pkg::DATA_W,
  parameter int BURST_W   = ddr_arbiter_pkg::BURST_W
) (
  input  logic                         clock,
  input  logic                         reset_n,

  input  logic [NUM_PORTS-1:0]         in_rd,
  input  logic [NUM_PORTS-1:0]         in_wr,
  input  logic [NUM_PORTS*ADDR_W-1:0]  in_addr,
  input  logic [NUM_PORTS*BURST_W-1:0] in_burst_len,
  input  logic [NUM_PORTS*8-1:0]       in_mask,
  input  logic [NUM_PORTS*DATA_W-1:0]  in_din,
  output logic [NUM_PORTS-1:0]         in_wait_req,
  output logic [NUM_PORTS-1:0]         in_valid,
  output logic [NUM_PORTS-1:0]         in_burst_done,
  output logic [DATA_W-1:0]            in_dout,

  output logic                         ddr_rd,
  output logic                         ddr_wr,
  output logic [ADDR_W-1:0]            ddr_addr,
  output logic [BURST_W-1:0]           ddr_burst_len,
  output logic [7:0]                   ddr_mask,
  output logic [DATA_W-1:0]            ddr_din,
  input  logic [DATA_W-1:0]            ddr_dout,
  input  logic                         ddr_wait_req,
  input  logic                         ddr_valid
);

  import ddr_arbiter_pkg::*;

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_t             state;
  logic [IDX_W-1:0]   grant;
  logic [BURST_W-1:0] beat_cnt;
  logic [BURST_W-1:0] len_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [7:0]         mask_q;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] win_onehot;
  logic [IDX_W-1:0]     win_idx;
  logic                 any_req;
  logic                 win_is_read;

  logic [ADDR_W-1:0]    win_addr;
  logic [BURST_W-1:0]   win_len;
  logic [7:0]           win_mask;

  logic                 grant_wr;
  logic [DATA_W-1:0]    grant_din;
  logic [7:0]           grant_mask;

  logic                 last_beat;
  logic                 rd_beat;
  logic                 wr_beat;

  assign req = in_rd | in_wr;

  prio_encoder #(.N(NUM_PORTS)) u_prio (
    .req    (req),
    .onehot (win_onehot),
    .idx    (win_idx),
    .any    (any_req)
  );

  // A port that raises rd and wr together is served as a read.
  assign win_is_read = |(win_onehot & in_rd);

  assign win_addr = in_addr[win_idx*ADDR_W +: ADDR_W];
  assign win_len  = in_burst_len[win_idx*BURST_W +: BURST_W];
  assign win_mask = in_mask[win_idx*8 +: 8];

  assign grant_wr   = in_wr[grant];
  assign grant_din  = in_din[grant*DATA_W +: DATA_W];
  assign grant_mask = in_mask[grant*8 +: 8];

  // len_q is never zero, so length 255 ends exactly at count 254 without wrapping.
  assign last_beat = (beat_cnt == len_q - 1'b1);
  assign rd_beat   = (state == READ_DATA) && ddr_valid;
  assign wr_beat   = (state == WRITE) && grant_wr && !ddr_wait_req;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values that were present before the clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      grant    <= '0;
      beat_cnt <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      mask_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant    <= win_idx;
            addr_q   <= win_addr;
            mask_q   <= win_mask;
            len_q    <= (win_len == '0) ? BURST_W'(1) : win_len;
            beat_cnt <= '0;
            state    <= win_is_read ? READ_CMD : WRITE;
          end
        end
        READ_CMD: begin
          if (!ddr_wait_req) begin
            beat_cnt <= '0;
            state    <= READ_DATA;
          end
        end
        READ_DATA: begin
          if (rd_beat) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) state <= IDLE;
          end
        end
        WRITE: begin
          if (wr_beat) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The DDR handshake is passed through to the granted port in the same cycle.
  // The read data, the valid strobes and the write data all stay combinational.
  always_comb begin
    in_wait_req   = '1;
    in_valid      = '0;
    in_burst_done = '0;
    in_dout       = '0;
    ddr_rd        = 1'b0;
    ddr_wr        = 1'b0;
    ddr_mask      = mask_q;
    ddr_din       = '0;
    case (state)
      READ_CMD: begin
        ddr_rd             = 1'b1;
        in_wait_req[grant] = ddr_wait_req;
      end
      READ_DATA: begin
        in_valid[grant]      = ddr_valid;
        in_dout              = ddr_dout;
        in_burst_done[grant] = rd_beat && last_beat;
      end
      WRITE: begin
        ddr_wr               = grant_wr;
        ddr_din              = grant_din;
        ddr_mask             = grant_mask;
        in_wait_req[grant]   = ddr_wait_req;
        in_burst_done[grant] = wr_beat && last_beat;
      end
      default: ;
    endcase
  end

  assign ddr_addr      = addr_q;
  assign ddr_burst_len = len_q;

  a_grant_in_range: assert property (
    @(posedge clock) disable iff (!reset_n) (state != IDLE) |-> (int'(grant) < NUM_PORTS)
  );

  a_done_onehot: assert property (
    @(posedge clock) disable iff (!reset_n) $onehot0(in_burst_done)
  );

endmodule

// File: doc/ddr_arbiter.md
Name: ddr_arbiter

Overview:
- Fixed-priority burst arbiter that shares the single DDRAM port between NUM_PORTS requesters.
- Requesters: port 0 = ROM download writer, port 1 = frame buffer, port 2 = tile/sprite ROM cache.
- Sits between these requesters and the top-level DDRAM_* pins, in the clk_sys domain.
- Grants one whole burst (read or write) at a time and routes the handshake and read data back to the winning port.

Parameters:
- NUM_PORTS, 3, number of requesters; port 0 has the highest priority.
- ADDR_W, 32, byte address width.
- DATA_W, 64, data width of one beat.
- BURST_W, 8, width of the burst length field.

Ports:
- clock  in  1  clk_sys.
- reset_n  in  1  asynchronous, active-low reset.
- in_rd  in  NUM_PORTS  per-port read request; held until in_wait_req[i] is low.
- in_wr  in  NUM_PORTS  per-port write beat valid; held until in_wait_req[i] is low.
- in_addr  in  NUM_PORTS*ADDR_W  per-port burst start byte address.
- in_burst_len  in  NUM_PORTS*BURST_W  per-port beats in the burst.
- in_mask  in  NUM_PORTS*8  per-port byte enables.
- in_din  in  NUM_PORTS*DATA_W  per-port write data.
- in_wait_req  out  NUM_PORTS  per-port stall.
- in_valid  out  NUM_PORTS  per-port read beat valid.
- in_burst_done  out  NUM_PORTS  one-cycle pulse on the last beat of a burst.
- in_dout  out  DATA_W  shared read data; qualify with in_valid.
- ddr_rd  out  1  to DDRAM_RD.
- ddr_wr  out  1  to DDRAM_WE.
- ddr_addr  out  ADDR_W  byte address; the top level uses [31:3].
- ddr_burst_len  out  BURST_W  to DDRAM_BURSTCNT.
- ddr_mask  out  8  to DDRAM_BE.
- ddr_din  out  DATA_W  to DDRAM_DIN.
- ddr_dout  in  DATA_W  from DDRAM_DOUT.
- ddr_wait_req  in  1  from DDRAM_BUSY.
- ddr_valid  in  1  from DDRAM_DOUT_READY.

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - state = IDLE, grant = 0, beat counter = 0.
  - ddr_rd = ddr_wr = 0; ddr_addr, ddr_burst_len, ddr_mask and ddr_din = 0.
  - in_wait_req = all 1; in_valid = in_burst_done = 0; in_dout = 0.
  - Reset mid-burst abandons the burst. The DDR side must be quiescent before reset is released; the arbiter does not drain stray beats.
- States: IDLE, READ_CMD, READ_DATA, WRITE.
- IDLE:
  - Requesting ports are those with in_rd | in_wr.
  - Winner = lowest-index requesting port.
  - Register grant index, address, mask and effective length. Effective length = in_burst_len, except 0 is treated as 1.
  - Next state: READ_CMD if the winner has in_rd, else WRITE. rd and wr together count as a read; wr is ignored.
  - No request: stay in IDLE.
  - in_wait_req stays all 1 in IDLE, so the first command reaches DDR one cycle after the request is seen.
- READ_CMD:
  - ddr_rd = 1; ddr_addr, ddr_burst_len and ddr_mask come from the registered values.
  - in_wait_req[grant] = ddr_wait_req.
  - When ddr_wait_req = 0: go to READ_DATA and clear the beat counter.
- READ_DATA:
  - in_valid[grant] = ddr_valid; in_dout = ddr_dout combinationally (zero added latency).
  - Each ddr_valid increments the counter.
  - On the beat where the counter equals effective length - 1: pulse in_burst_done[grant] and return to IDLE.
  - ddr_valid outside READ_DATA is ignored.
- WRITE:
  - ddr_wr = in_wr[grant]; ddr_din = in_din[grant]; ddr_mask = in_mask[grant].
  - ddr_addr and ddr_burst_len come from the registered values.
  - in_wait_req[grant] = ddr_wait_req.
  - A beat is accepted when in_wr[grant] & ~ddr_wait_req; the counter increments.
  - On the last accepted beat: pulse in_burst_done[grant] and go to IDLE.
  - Requester gaps (in_wr = 0) are legal; the arbiter waits.
- Preemption:
  - None; a granted burst always completes.
  - Re-arbitration happens in the IDLE cycle after in_burst_done, so there is a minimum one-cycle gap between bursts.
- Non-granted ports always see in_wait_req = 1 and in_valid = 0.
- Counter width is BURST_W. Length 255 must not wrap early; length 0 is treated as 1.
- Starvation of low-priority ports is accepted by design. Port 0 is only active during download.

Decomposition:
- Package ddr_arbiter_pkg holds:
  - state enum (IDLE, READ_CMD, READ_DATA, WRITE);
  - port index constants PORT_DOWNLOAD = 0, PORT_FB = 1, PORT_CACHE = 2;
  - widths ADDR_W, DATA_W, BURST_W.
- One sub-module, prio_encoder: NUM_PORTS request vector in, lowest-index one-hot grant and index out, plus an any-request flag.
- Beat counting and the state machine stay in ddr_arbiter.

Test Plan:
- Single read:
  - Stimulus: port 1 reads addr 0x0000_1000, len 4; DDR holds wait_req for 2 cycles, then returns 4 beats 0xA0..0xA3.
  - Response: ddr_rd asserted 1 cycle after in_rd; port 1 sees in_valid on 4 beats with data 0xA0..0xA3; in_burst_done on beat 4; state back to IDLE.
- Priority:
  - Stimulus: ports 0 (write, len 2), 1 and 2 (reads) all request in the same cycle.
  - Response: order is port 0, then 1, then 2; each port's in_wait_req stays 1 until its own grant; one IDLE cycle between bursts.
- Write with gaps:
  - Stimulus: port 0 writes len 3, data 0x11/0x22/0x33, with in_wr low for 2 cycles between beats; ddr_wait_req toggles.
  - Response: exactly 3 accepted beats with the correct data and mask; in_burst_done on the 3rd accepted beat.
- Boundary lengths:
  - len 0 read → 1 beat, then burst_done.
  - len 255 read → exactly 255 valid beats before burst_done; no early exit.
- Read ignores write:
  - Stimulus: port 2 asserts in_rd and in_wr together.
  - Response: read burst; ddr_wr stays 0.
- Reset mid-operation:
  - Stimulus: reset_n = 0 asynchronously in READ_DATA after beat 2 of 4.
  - Response: outputs return to reset values immediately; after release with no requests, the arbiter stays in IDLE with ddr_rd = ddr_wr = 0.
